// File: rtl/ibex_qed_pkg.sv
// rtl/ibex_qed_pkg.sv - shared types and helpers for the QED register file
package ibex_qed_pkg;

  typedef enum logic [1:0] {
    QED_IDLE,
    QED_SCAN,
    QED_DONE,
    QED_FAIL
  } qed_chk_state_e;

  function automatic int qed_addr_width(input int num_orig);
    return $clog2(2 * num_orig);
  endfunction

endpackage

// File: rtl/ibex_qed_commit_counter.sv
// rtl/ibex_qed_commit_counter.sv - saturating commit counter with sticky saturation flag
module ibex_qed_commit_counter #(
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                sat_o
);

  logic [CntWidth-1:0] cnt;
  logic                sat;

  // Upper bits all ones while not yet all-ones means this increment lands on the maximum.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc_i && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
      if (&cnt[CntWidth-1:1]) begin
        sat <= 1'b1;
      end
    end
  end

  assign cnt_o = cnt;
  assign sat_o = sat;

endmodule

// File: rtl/ibex_qed_register_file.sv
// rtl/ibex_qed_register_file.sv - parametrised SQED register file with commit tracking
// and a sequential original/duplicate consistency scan.
module ibex_qed_register_file
  import ibex_qed_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int NumOrig   = 16,
  parameter int NumRead   = 2,
  parameter int CntWidth  = 16,
  localparam int AddrWidth = qed_addr_width(NumOrig)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         we_i,
  input  logic [AddrWidth-1:0]         waddr_i,
  input  logic [DataWidth-1:0]         wdata_i,
  input  logic                         qed_vld_i,
  input  logic [NumRead*AddrWidth-1:0] raddr_i,
  output logic [NumRead*DataWidth-1:0] rdata_o,
  output logic [CntWidth-1:0]          num_orig_o,
  output logic [CntWidth-1:0]          num_dup_o,
  output logic                         cnt_sat_o,
  output logic                         qed_ready_o,
  output logic                         check_busy_o,
  output logic                         check_done_o,
  output logic                         check_fail_o,
  output logic [AddrWidth-2:0]         fail_idx_o
);

  localparam int IdxWidth = AddrWidth - 1;

  logic [DataWidth-1:0] regs [2*NumOrig];

  // Word 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2 * NumOrig; i++) begin
        regs[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  for (genvar k = 0; k < NumRead; k++) begin : g_read
    assign rdata_o[k*DataWidth +: DataWidth] = regs[raddr_i[k*AddrWidth +: AddrWidth]];
  end

  logic commit, orig_commit, dup_commit;
  logic sat_orig, sat_dup;

  assign commit      = we_i & qed_vld_i & (waddr_i != '0);
  assign orig_commit = commit & ~waddr_i[AddrWidth-1];
  assign dup_commit  = commit &  waddr_i[AddrWidth-1];

  ibex_qed_commit_counter #(.CntWidth(CntWidth)) u_orig_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (orig_commit),
    .cnt_o (num_orig_o),
    .sat_o (sat_orig)
  );

  ibex_qed_commit_counter #(.CntWidth(CntWidth)) u_dup_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (dup_commit),
    .cnt_o (num_dup_o),
    .sat_o (sat_dup)
  );

  assign cnt_sat_o   = sat_orig | sat_dup;
  assign qed_ready_o = (num_orig_o == num_dup_o) && (num_orig_o != '0);

  qed_chk_state_e       state, state_next;
  logic [IdxWidth-1:0]  idx, idx_next;
  logic [IdxWidth-1:0]  fail_idx, fail_idx_next;
  logic                 ready_q;
  logic                 trigger;
  logic                 mismatch;

  assign trigger = qed_ready_o & ~ready_q;
  // NumOrig is a power of two, so the duplicate of idx is idx with the top address bit set.
  assign mismatch = regs[{1'b0, idx}] != regs[{1'b1, idx}];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= QED_IDLE;
      idx      <= '0;
      fail_idx <= '0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      fail_idx <= fail_idx_next;
      ready_q  <= qed_ready_o;
    end
  end

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    fail_idx_next = fail_idx;
    case (state)
      QED_IDLE: begin
        if (trigger) begin
          state_next = QED_SCAN;
          idx_next   = '0;
        end
      end
      QED_SCAN: begin
        if (mismatch) begin
          state_next    = QED_FAIL;
          fail_idx_next = idx;
        end else if (commit) begin
          state_next = QED_IDLE;
        end else if (idx == IdxWidth'(NumOrig - 1)) begin
          state_next = QED_DONE;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      QED_DONE: state_next = QED_IDLE;
      QED_FAIL: state_next = QED_FAIL;
      default:  state_next = QED_IDLE;
    endcase
  end

  assign check_busy_o = (state == QED_SCAN);
  assign check_done_o = (state == QED_DONE);
  assign check_fail_o = (state == QED_FAIL);
  assign fail_idx_o   = fail_idx;

endmodule

// File: tb/tb_ibex_qed_register_file.sv
// tb/tb_ibex_qed_register_file.sv - directed bench for the QED register file
module tb_ibex_qed_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, qed;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [15:0] num_orig, num_dup;
  logic        cnt_sat, ready, busy, done, fail;
  logic [3:0]  fail_idx;

  logic        we_b, qed_b;
  logic [4:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [9:0]  raddr_b;
  logic [63:0] rdata_b;
  logic [3:0]  num_orig_b, num_dup_b;
  logic        cnt_sat_b, ready_b, busy_b, done_b, fail_b;
  logic [3:0]  fail_idx_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ibex_qed_register_file dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .qed_vld_i(qed), .raddr_i(raddr), .rdata_o(rdata),
    .num_orig_o(num_orig), .num_dup_o(num_dup), .cnt_sat_o(cnt_sat),
    .qed_ready_o(ready), .check_busy_o(busy), .check_done_o(done),
    .check_fail_o(fail), .fail_idx_o(fail_idx)
  );

  ibex_qed_register_file #(.CntWidth(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .we_i(we_b), .waddr_i(waddr_b), .wdata_i(wdata_b),
    .qed_vld_i(qed_b), .raddr_i(raddr_b), .rdata_o(rdata_b),
    .num_orig_o(num_orig_b), .num_dup_o(num_dup_b), .cnt_sat_o(cnt_sat_b),
    .qed_ready_o(ready_b), .check_busy_o(busy_b), .check_done_o(done_b),
    .check_fail_o(fail_b), .fail_idx_o(fail_idx_b)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        qed;
    logic [4:0]  ra0, ra1;
    logic [31:0] exp_r0, exp_r1;
    logic [15:0] exp_orig, exp_dup;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic q);
    we = 1'b1; waddr = a; wdata = d; qed = q;
    step();
    we = 1'b0; qed = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic full_scan_pass(input string tag);
    chk({tag, "_ready_T"}, ready, 1);
    chk({tag, "_busy_T"}, busy, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done_early"}, done, 0);
    end
    step();
    chk({tag, "_done_T17"}, done, 1);
    chk({tag, "_busy_T17"}, busy, 0);
    chk({tag, "_fail"}, fail, 0);
    step();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; we = 0; qed = 0; waddr = 0; wdata = 0; raddr = 0;
    we_b = 0; qed_b = 0; waddr_b = 0; wdata_b = 0; raddr_b = 0;

    vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b1, 5'd0,  5'd0,  32'h0,        32'h0,        16'd0, 16'd0, 1'b0};
    vecs[1] = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd5,  5'd0,  32'h1234,     32'h0,        16'd0, 16'd0, 1'b0};
    vecs[2] = '{1'b0, 5'd6,  32'h99,       1'b1, 5'd6,  5'd5,  32'h0,        32'h1234,     16'd0, 16'd0, 1'b0};
    vecs[3] = '{1'b1, 5'd21, 32'h1234,     1'b0, 5'd21, 5'd5,  32'h1234,     32'h1234,     16'd0, 16'd0, 1'b0};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 5'd31, 5'd15, 32'hA5A5A5A5, 32'h0,        16'd0, 16'd0, 1'b0};
    vecs[5] = '{1'b1, 5'd15, 32'hA5A5A5A5, 1'b0, 5'd15, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'd0, 16'd0, 1'b0};
    vecs[6] = '{1'b1, 5'd24, 32'h88,       1'b0, 5'd24, 5'd8,  32'h88,       32'h88,       16'd0, 16'd0, 1'b0};
    vecs[7] = '{1'b1, 5'd2,  32'h5,        1'b1, 5'd2,  5'd18, 32'h5,        32'h0,        16'd1, 16'd0, 1'b0};
    vecs[8] = '{1'b1, 5'd18, 32'h5,        1'b1, 5'd18, 5'd2,  32'h5,        32'h5,        16'd1, 16'd1, 1'b1};

    do_reset();
    for (int a = 0; a < 32; a += 2) begin
      raddr = {5'(a + 1), 5'(a)};
      #1;
      chk("reset_rdata", rdata, 64'h0);
    end
    chk("reset_orig", num_orig, 0);
    chk("reset_dup", num_dup, 0);
    chk("reset_flags", {cnt_sat, ready, busy, done, fail}, 0);
    chk("reset_fail_idx", fail_idx, 0);

    we = 1'b1; waddr = 5'd8; wdata = 32'h88; qed = 1'b0; raddr = {5'd0, 5'd8};
    #1;
    chk("no_bypass", rdata[31:0], 32'h0);
    step();
    chk("write_next_cycle", rdata[31:0], 32'h88);

    for (int i = 0; i < 9; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata; qed = vecs[i].qed;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      step();
      chk($sformatf("vec%0d_r0", i), rdata[31:0], vecs[i].exp_r0);
      chk($sformatf("vec%0d_r1", i), rdata[63:32], vecs[i].exp_r1);
      chk($sformatf("vec%0d_orig", i), num_orig, vecs[i].exp_orig);
      chk($sformatf("vec%0d_dup", i), num_dup, vecs[i].exp_dup);
      chk($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready);
    end
    we = 1'b0; qed = 1'b0;
    full_scan_pass("pass_scan");

    do_reset();
    wr(5'd2, 32'h5, 1'b1);
    we = 1'b1; waddr = 5'd18; wdata = 32'h6; qed = 1'b1;
    step();
    we = 1'b0; qed = 1'b0;
    chk("mm_ready_T", ready, 1);
    step(); step(); step();
    chk("mm_no_fail_T3", fail, 0);
    chk("mm_busy_T3", busy, 1);
    step();
    chk("mm_fail_T4", fail, 1);
    chk("mm_idx_T4", fail_idx, 2);
    for (int i = 0; i < 20; i++) wr(5'(1 + (i % 30)), 32'(i), 1'b1);
    step();
    chk("mm_fail_held", fail, 1);
    chk("mm_idx_held", fail_idx, 2);
    chk("mm_busy_held", busy, 0);
    do_reset();
    chk("mm_reset_fail", fail, 0);
    chk("mm_reset_idx", fail_idx, 0);
    chk("mm_reset_orig", num_orig, 0);

    wr(5'd2, 32'h5, 1'b1);
    wr(5'd18, 32'h5, 1'b1);
    chk("ab_ready_T", ready, 1);
    for (int i = 0; i < 6; i++) step();
    chk("ab_busy_idx5", busy, 1);
    wr(5'd3, 32'h9, 1'b1);
    chk("ab_idle", busy, 0);
    chk("ab_no_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ab_stay_idle", {busy, done, fail, ready}, 0);
    end
    wr(5'd19, 32'h9, 1'b1);
    full_scan_pass("restart_scan");

    for (int k = 1; k <= 16; k++) begin
      we_b = 1'b1; waddr_b = 5'(1 + (k % 15)); wdata_b = 32'(k); qed_b = 1'b1;
      step();
      chk($sformatf("sat_cnt%0d", k), num_orig_b, (k < 15) ? 4'(k) : 4'hF);
      chk($sformatf("sat_flag%0d", k), cnt_sat_b, (k >= 15) ? 1'b1 : 1'b0);
    end
    we_b = 1'b0; qed_b = 1'b0;
    step();
    chk("sat_dup_zero", num_dup_b, 0);
    chk("sat_hold", num_orig_b, 4'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
